// File: rtl/regfile_pkg.sv
// Shared constants, types and helpers for the
// register-file write-back path.
package regfile_pkg;

    localparam int NREG   = 16;
    localparam int DATA_W = 32;
    localparam int IDX_W  = 4;

    typedef struct packed {
        logic [IDX_W-1:0]  idx;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    function automatic logic [NREG-1:0] onehot_decode(
        input logic [IDX_W-1:0] idx
    );
        logic [NREG-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/regfile_write_buffer_dec.sv
// Register index to one-hot write-enable decoder.
// Output is all-zero when not enabled.
module reg_index_decoder
    import regfile_pkg::*;
(
    input  logic             en,
    input  logic [IDX_W-1:0] idx,
    output logic [NREG-1:0]  onehot
);

    // gate the decoded index with the enable
    always_comb begin
        onehot = '0;
        if (en) onehot = onehot_decode(idx);
    end

endmodule

// File: rtl/regfile_write_buffer.sv
// In-order write-back FIFO in front of the register
// file, draining one entry per cycle, with bypass.
module regfile_write_buffer
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [IDX_W-1:0]         in_reg,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     wb_hold,
    output logic [NREG-1:0]          write,
    output logic [DATA_W-1:0]        D,
    input  logic [IDX_W-1:0]         rd_reg,
    output logic                     byp_hit,
    output logic [DATA_W-1:0]        byp_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry_t        mem [DEPTH];
    logic [DEPTH-1:0] vld;
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic             push;
    logic             pop;
    wb_entry_t        hd;

    assign in_ready = (count < CW'(DEPTH));
    assign empty    = (count == '0);
    assign push     = in_valid && in_ready;
    assign pop      = !empty && !wb_hold && !clr;
    assign hd       = mem[head];
    assign D        = pop ? hd.data : '0;

    reg_index_decoder u_dec (
        .en     (pop),
        .idx    (hd.idx),
        .onehot (write)
    );

    // FIFO pointers, occupancy and entry storage
    always_ff @(posedge clk) begin
        if (clr) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            vld   <= '0;
        end else begin
            if (pop) begin
                vld[head] <= 1'b0;
                head      <= head + 1'b1;
            end
            if (push) begin
                mem[tail].idx  <= in_reg;
                mem[tail].data <= in_data;
                vld[tail]      <= 1'b1;
                tail           <= tail + 1'b1;
            end
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    // oldest-to-newest scan so the newest match wins
    always_comb begin
        byp_hit  = 1'b0;
        byp_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (vld[head + PW'(k)] &&
                mem[head + PW'(k)].idx == rd_reg) begin
                byp_hit  = 1'b1;
                byp_data = mem[head + PW'(k)].data;
            end
        end
    end

endmodule

// File: doc/regfile_write_buffer.md
Name: regfile_write_buffer

Overview:
Write-back buffer that sits directly upstream of the 16 x 32-bit general register file. It accepts register write requests (register index plus data) from the datapath over a valid/ready handshake and holds them in a small in-order FIFO. It drains one entry per cycle onto the register file's one-hot write-enable vector and data input. It also provides a bypass lookup, so a read of a register with a pending write returns the newest buffered value.

Parameters:
DEPTH, 4, number of buffered write requests (power of two, >= 2)
DATA_W, 32, register data width
NREG, 16, number of architectural registers
IDX_W, 4, register index width (log2 NREG)

Ports:
clk  input  1  system clock, rising-edge
clr  input  1  synchronous active-high reset
in_valid  input  1  write request present
in_ready  output  1  buffer can accept a request this cycle
in_reg  input  IDX_W  destination register index
in_data  input  DATA_W  value to write
wb_hold  input  1  suppress draining this cycle
write  output  NREG  one-hot write enable to register file
D  output  DATA_W  write data to register file
rd_reg  input  IDX_W  register index for bypass lookup
byp_hit  output  1  rd_reg has a pending buffered write
byp_data  output  DATA_W  newest buffered value for rd_reg
count  output  log2(DEPTH)+1  number of occupied entries
empty  output  1  count == 0

Behaviour:
- Interface: one clock domain, clk. Reset is clr, synchronous and active-high. Every register updates only on the rising edge of clk.
- Reset (clr high at an edge):
  - count=0; head and tail pointers=0; all entry valid bits cleared.
  - Results after reset: in_ready=1, empty=1, write=0, D=0, byp_hit=0, byp_data=0.
  - While clr is high, write is forced to 0. Pending entries are discarded, never written.
- Push:
  - Occurs when in_valid && in_ready at an edge.
  - in_reg and in_data are stored at tail; tail advances modulo DEPTH.
  - in_ready = (count < DEPTH), derived from registered state only. There is no combinational path from wb_hold or a pop to in_ready.
  - When full, in_ready=0 even in a cycle that pops.
- Drain:
  - When count>0 && !wb_hold && !clr: write = one-hot decode of the head entry's reg index, and D = head data. Both are combinational from registered head state.
  - The head pops at the same edge. The register file captures the value at that edge, so latency is one cycle from drain-visible to register updated.
  - Otherwise write=0 and D=0.
  - At most one bit of write is high in any cycle.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Ordering: strict FIFO. Duplicate destinations are not coalesced; each entry drains in turn, so the last write wins in the register file.
- R0: treated as an ordinary register. Writes to index 0 are buffered and drained normally.
- Bypass:
  - Combinational over all valid stored entries, including the head being drained this cycle.
  - byp_hit=1 when any valid entry's index equals rd_reg. byp_data is the data of the newest matching entry, searched tail-1 backward to head.
  - When there is no hit, byp_data=0.
  - The request currently on in_* (not yet stored) is not searched.
- Pointer wrap: both pointers are IDX of log2(DEPTH) bits and wrap naturally. count disambiguates full from empty.
- wb_hold while empty: no effect.
- wb_hold while full: in_ready stays 0 and no entry is lost.

Decomposition:
- Shared package (regfile_pkg):
  - NREG, DATA_W, IDX_W constants.
  - wb_entry_t struct {reg idx, data}.
  - onehot_decode function.
- Natural sub-module: reg_index_decoder, an IDX_W to NREG one-hot decoder with an enable input. It produces write, and the register file's write-select logic can reuse it.
- FIFO storage and bypass search stay in the top module.

Test Plan:
- Reset then idle: assert clr for 2 cycles with in_valid=1 -> write=0, count=0, in_ready=1, empty=1; nothing stored.
- Single write: push reg 5 = 0xDEADBEEF with wb_hold=0 -> next cycle write=16'h0020, D=0xDEADBEEF for exactly one cycle, then empty=1.
- Fill and back-pressure:
  - Stimulus: wb_hold=1; push regs 1,2,3,4 = 0x11,0x22,0x33,0x44.
  - After 4 pushes: count=4, in_ready=0, and a fifth request (reg 6) is not accepted.
  - Release wb_hold: write=0x0002, 0x0004, 0x0008, 0x0010 on consecutive cycles with matching D.
- Bypass newest-wins:
  - Stimulus: wb_hold=1; push reg 7=0xA, then reg 9=0xB, then reg 7=0xC.
  - rd_reg=7 -> byp_hit=1, byp_data=0xC. rd_reg=9 -> 0xB. rd_reg=3 -> byp_hit=0, byp_data=0.
- Simultaneous push/pop: with count=2, push reg 0 = 0x5A while draining -> count stays 2. The reg 0 entry drains last with write=16'h0001, D=0x5A.
- Reset mid-operation: with 3 entries pending, assert clr for one cycle -> write=0 that cycle, count=0 after the edge, and none of the 3 entries are ever written.
